// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: parses SYNC/count/words/checksum frames, writes
// assembled instruction words from address 0 and holds the CPU until a verified image is in.
module instr_mem_loader #(
  parameter int unsigned INSTR_WIDTH = 19,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   in_valid_i,
  input  logic [7:0]             in_data_i,
  output logic                   in_ready_o,
  output logic                   imem_we_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  output logic [INSTR_WIDTH-1:0] imem_wdata_o,
  output logic                   cpu_hold_o,
  output logic                   load_done_o,
  output logic                   load_error_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CNT_HI = 4'd1,
    S_CNT_LO = 4'd2,
    S_W0     = 4'd3,
    S_W1     = 4'd4,
    S_W2     = 4'd5,
    S_CHK    = 4'd6,
    S_DONE   = 4'd7,
    S_ERR    = 4'd8
  } state_t;

  // Bits of the first word byte that lie above INSTR_WIDTH and must be zero.
  localparam logic [7:0]  W0_MASK  = 8'(8'hFF << (INSTR_WIDTH - 16));
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t                  state_q, state_d;
  logic                    ready_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [INSTR_WIDTH-1:0]  wdata_q;
  logic                    hold_q;
  logic                    done_q;
  logic                    error_q;
  logic [7:0]              chk_q;
  logic [7:0]              cnt_hi_q;
  logic [7:0]              b0_q;
  logic [7:0]              b1_q;
  logic [ADDR_WIDTH:0]     n_q;
  logic [ADDR_WIDTH:0]     idx_q;

  logic                    accept_s;
  logic                    sync_s;
  logic                    chk_upd_s;
  logic                    wr_s;
  logic [15:0]             n_full_s;
  logic [ADDR_WIDTH:0]     idx_inc_s;
  logic [INSTR_WIDTH-1:0]  word_s;

  assign accept_s  = in_valid_i & ready_q;
  assign n_full_s  = {cnt_hi_q, in_data_i};
  assign idx_inc_s = idx_q + (ADDR_WIDTH+1)'(1'b1);
  assign word_s    = INSTR_WIDTH'({b0_q, b1_q, in_data_i});

  // Next-state and per-byte control strobes; nothing moves without an accepted byte.
  always_comb begin
    state_d   = state_q;
    sync_s    = 1'b0;
    chk_upd_s = 1'b0;
    wr_s      = 1'b0;
    if (accept_s) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (in_data_i == SYNC_BYTE) begin
            state_d = S_CNT_HI;
            sync_s  = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        S_CNT_HI: begin
          state_d   = S_CNT_LO;
          chk_upd_s = 1'b1;
        end
        S_CNT_LO: begin
          chk_upd_s = 1'b1;
          if ({1'b0, n_full_s} > CAPACITY) begin
            state_d = S_ERR;
          end else if (n_full_s == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_W0;
          end
        end
        S_W0: begin
          if ((in_data_i & W0_MASK) != 8'd0) begin
            state_d = S_ERR;
          end else begin
            state_d   = S_W1;
            chk_upd_s = 1'b1;
          end
        end
        S_W1: begin
          state_d   = S_W2;
          chk_upd_s = 1'b1;
        end
        S_W2: begin
          chk_upd_s = 1'b1;
          wr_s      = 1'b1;
          if (idx_inc_s == n_q) begin
            state_d = S_CHK;
          end else begin
            state_d = S_W0;
          end
        end
        S_CHK: begin
          if (in_data_i == chk_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end
        S_ERR:   state_d = S_ERR;
        default: state_d = S_ERR;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      chk_q    <= 8'd0;
      cnt_hi_q <= 8'd0;
      b0_q     <= 8'd0;
      b1_q     <= 8'd0;
      n_q      <= '0;
      idx_q    <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      we_q    <= wr_s;
      done_q  <= (state_d == S_DONE);
      error_q <= (state_d == S_ERR);
      hold_q  <= (state_d != S_DONE);

      if (sync_s) begin
        chk_q <= 8'd0;
      end else if (chk_upd_s) begin
        chk_q <= chk_update(chk_q, in_data_i);
      end

      if (sync_s) begin
        idx_q <= '0;
      end else if (wr_s) begin
        idx_q <= idx_inc_s;
      end

      if (wr_s) begin
        addr_q  <= idx_q[ADDR_WIDTH-1:0];
        wdata_q <= word_s;
      end

      if (accept_s && state_q == S_CNT_HI) cnt_hi_q <= in_data_i;
      if (accept_s && state_q == S_CNT_LO) n_q <= n_full_s[ADDR_WIDTH:0];
      if (accept_s && state_q == S_W0) b0_q <= in_data_i;
      if (accept_s && state_q == S_W1) b1_q <= in_data_i;
    end
  end

  assign in_ready_o   = ready_q;
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign cpu_hold_o   = hold_q;
  assign load_done_o  = done_q;
  assign load_error_o = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader: byte streams with random valid gaps are
// checked against a frame-parsing reference model of the accepted byte stream.
module tb_instr_mem_loader;
  localparam int IW  = 19;
  localparam int AW  = 12;
  localparam int CAP = 1 << AW;
  localparam logic [7:0]  TOP_MASK = 8'hFF << (IW - 16);
  localparam logic [23:0] DMASK    = (24'd1 << IW) - 24'd1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;

  instr_mem_loader #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .imem_we_o(imem_we), .imem_addr_o(imem_addr),
    .imem_wdata_o(imem_wdata), .cpu_hold_o(cpu_hold), .load_done_o(load_done),
    .load_error_o(load_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0]    stream_q[$];
  logic [7:0]    fq[$];
  logic [AW-1:0] obs_addr_q[$];
  logic [IW-1:0] obs_data_q[$];
  int            exp_addr_q[$];
  logic [23:0]   exp_data_q[$];
  bit            m_done;
  bit            m_err;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // write monitor
  always @(negedge clk) begin
    if (!reset && imem_we) begin
      obs_addr_q.push_back(imem_addr);
      obs_data_q.push_back(imem_wdata);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_ready", in_ready, 0);
    chk_eq("rst_we", imem_we, 0);
    chk_eq("rst_addr", imem_addr, 0);
    chk_eq("rst_wdata", imem_wdata, 0);
    chk_eq("rst_hold", cpu_hold, 1);
    chk_eq("rst_done", load_done, 0);
    chk_eq("rst_err", load_error, 0);
    reset = 1'b0;
    stream_q.delete(); obs_addr_q.delete(); obs_data_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap = 0;
    bit ok = 1'b0;
    logic r;
    if (maxgap > 0 && $urandom_range(0, 3) == 0) gap = $urandom_range(1, maxgap);
    repeat (gap) begin @(negedge clk); in_valid = 1'b0; end
    @(negedge clk);
    in_valid = 1'b1; in_data = b;
    for (int t = 0; t < 50; t++) begin
      r = in_ready;
      @(posedge clk);
      if (r) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) stream_q.push_back(b);
    else chk_eq("ready_timeout", 0, 1);
  endtask

  task automatic send_fq(input int from, input int maxgap);
    for (int i = from; i < fq.size(); i++) send_byte(fq[i], maxgap);
  endtask

  task automatic end_stream();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic build_frame(input int n, input int kind);
    logic [7:0]  cs;
    logic [23:0] w;
    int bad;
    bad = (n > 0) ? $urandom_range(0, n - 1) : 0;
    fq.delete();
    fq.push_back(8'hA5); fq.push_back(8'(n >> 8)); fq.push_back(8'(n));
    cs = 8'(n >> 8) ^ 8'(n);
    for (int i = 0; i < n; i++) begin
      w = 24'($urandom) & DMASK;
      if (kind == 2 && i == bad) w[23] = 1'b1;
      fq.push_back(w[23:16]); fq.push_back(w[15:8]); fq.push_back(w[7:0]);
      cs = cs ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    fq.push_back((kind == 1) ? (cs ^ 8'h5A) : cs);
  endtask

  // Reference: parse the accepted byte stream frame by frame.
  task automatic run_model();
    int p = 0;
    int sz;
    int unsigned n;
    logic [7:0]  cs;
    logic [23:0] w;
    bit stop = 1'b0;
    exp_addr_q.delete(); exp_data_q.delete();
    m_done = 1'b0; m_err = 1'b0;
    sz = stream_q.size();
    while (!stop && p < sz) begin
      if (stream_q[p] != 8'hA5) begin
        p++;
      end else begin
        p++;
        m_done = 1'b0;
        if (p + 2 > sz) begin
          stop = 1'b1;
        end else begin
          n  = {stream_q[p], stream_q[p+1]};
          cs = stream_q[p] ^ stream_q[p+1];
          p += 2;
          if (n > CAP) begin m_err = 1'b1; stop = 1'b1; end
          for (int i = 0; i < int'(n) && !stop; i++) begin
            if (p >= sz) stop = 1'b1;
            else if ((stream_q[p] & TOP_MASK) != 8'd0) begin m_err = 1'b1; stop = 1'b1; end
            else if (p + 3 > sz) stop = 1'b1;
            else begin
              w  = {stream_q[p], stream_q[p+1], stream_q[p+2]};
              cs = cs ^ stream_q[p] ^ stream_q[p+1] ^ stream_q[p+2];
              exp_addr_q.push_back(i);
              exp_data_q.push_back(w & DMASK);
              p += 3;
            end
          end
          if (!stop) begin
            if (p >= sz) stop = 1'b1;
            else if (stream_q[p] == cs) begin m_done = 1'b1; p++; end
            else begin m_err = 1'b1; stop = 1'b1; end
          end
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    int ne;
    run_model();
    chk_eq({tag, "_done"}, load_done, m_done);
    chk_eq({tag, "_err"}, load_error, m_err);
    chk_eq({tag, "_hold"}, cpu_hold, !m_done);
    #2;
    ne = exp_addr_q.size();
    chk_eq({tag, "_nwrites"}, obs_addr_q.size(), ne);
    for (int i = 0; i < ne && i < obs_addr_q.size(); i++) begin
      chk_eq($sformatf("%s_addr%0d", tag, i), obs_addr_q[i], exp_addr_q[i]);
      chk_eq($sformatf("%s_data%0d", tag, i), obs_data_q[i], exp_data_q[i]);
    end
    chk_eq({tag, "_addr_hold"}, imem_addr, (ne > 0) ? exp_addr_q[ne-1] : 0);
    chk_eq({tag, "_wdata_hold"}, imem_wdata, (ne > 0) ? exp_data_q[ne-1] : 24'd0);
  endtask

  task automatic load_list(input logic [7:0] bytes[$]);
    fq = bytes;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    do_reset();

    // known good frame
    load_list('{8'hA5, 8'h00, 8'h02, 8'h00, 8'h12, 8'h34, 8'h07, 8'hFF, 8'hFF, 8'h23});
    send_fq(0, 3); end_stream();
    check_model("good");
    chk_eq("good_const_n", obs_data_q.size(), 2);
    if (obs_data_q.size() == 2) begin
      chk_eq("good_const_w0", obs_data_q[0], 19'h01234);
      chk_eq("good_const_w1", obs_data_q[1], 19'h7FFFF);
    end
    chk_eq("good_const_done", load_done, 1);

    // reload from DONE: hold rises one cycle after the A5
    build_frame(3, 0);
    chk_eq("reload_pre_hold", cpu_hold, 0);
    send_byte(fq[0], 0);
    @(negedge clk); in_valid = 1'b0;
    chk_eq("reload_hold_rise", cpu_hold, 1);
    chk_eq("reload_done_fall", load_done, 0);
    send_fq(1, 3); end_stream();
    check_model("reload");

    // bad checksum, then ignored traffic
    do_reset();
    load_list('{8'hA5, 8'h00, 8'h02, 8'h00, 8'h12, 8'h34, 8'h07, 8'hFF, 8'hFF, 8'h24});
    send_fq(0, 2); end_stream();
    check_model("badchk");
    load_list('{8'hA5, 8'h00, 8'h00, 8'h00});
    send_fq(0, 2); end_stream();
    check_model("err_absorb");
    chk_eq("err_absorb_const", load_error, 1);

    // bad upper bits in W0
    do_reset();
    load_list('{8'hA5, 8'h00, 8'h01, 8'h08});
    send_fq(0, 2); end_stream();
    check_model("badtop");
    load_list('{8'h00, 8'h00, 8'h08});
    send_fq(0, 2); end_stream();
    check_model("badtop_tail");

    // empty image
    do_reset();
    load_list('{8'hA5, 8'h00, 8'h00, 8'h00});
    send_fq(0, 2); end_stream();
    check_model("empty");

    // oversize image
    do_reset();
    load_list('{8'hA5, 8'h10, 8'h01});
    send_fq(0, 2); end_stream();
    check_model("oversize");

    // garbage before sync
    do_reset();
    load_list('{8'h00, 8'hFF});
    send_fq(0, 2);
    build_frame(4, 0); send_fq(0, 3); end_stream();
    check_model("garbage");

    // reset after the W1 byte, then a full frame
    do_reset();
    load_list('{8'hA5, 8'h00, 8'h01, 8'h01, 8'h02});
    send_fq(0, 1); end_stream();
    check_model("partial");
    do_reset();
    build_frame(5, 0); send_fq(0, 3); end_stream();
    check_model("after_partial");

    // exact capacity fill
    do_reset();
    build_frame(CAP, 0); send_fq(0, 1); end_stream();
    check_model("fill");
    chk_eq("fill_last_addr", imem_addr, 12'hFFF);

    // random frames
    do_reset();
    for (int it = 0; it < 12; it++) begin
      int kind;
      kind = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      if ($urandom_range(0, 2) == 0) send_byte(8'($urandom_range(0, 8'hA4)), 2);
      build_frame($urandom_range(0, 20), kind);
      send_fq(0, 4); end_stream();
      check_model($sformatf("rnd%0d", it));
      if (m_err) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
